// File: rtl/vga_text_renderer.sv
// Text-mode pixel generator: 80x30 character cells drawn from an external text RAM and font ROM, output as RGB332.
// Latency: 4 dclk from hc/vc/hsync_in/vsync_in to rgb/hsync_out/vsync_out; the syncs travel in the same pipeline as the pixels.
// Backpressure: none; one pixel is accepted and produced every cycle.
//
// Ports:
//   dclk, clr               pixel clock and synchronous active-high reset
//   hc, vc                  800x521 timing counters; hsync_in/vsync_in are the raw active-low syncs
//   text_addr/text_data     text RAM port (1-cycle read): [6:0] char, [7] blink, [15:8] fg
//   font_addr/font_data     font ROM port (1-cycle read): {char, glyph_row} -> 8-pixel row, bit7 leftmost
//   cursor_en/col/row       hardware cursor: underline on glyph rows 14-15, shown only in the visible blink phase
//   rgb, hsync_out, vsync_out  registered pixel and the delayed syncs
module vga_text_renderer #(
    parameter int HBP  = 144,
    parameter int VBP  = 31,
    parameter int HACT = 640,
    parameter int VACT = 480,
    parameter int COLS = 80,
    parameter int ROWS = 30
) (
    input  logic        dclk,
    input  logic        clr,
    input  logic [9:0]  hc,
    input  logic [9:0]  vc,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [11:0] text_addr,
    input  logic [15:0] text_data,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_data,
    input  logic        cursor_en,
    input  logic [6:0]  cursor_col,
    input  logic [4:0]  cursor_row,
    output logic [7:0]  rgb,
    output logic        hsync_out,
    output logic        vsync_out
);

    // Position decode for the incoming counters
    logic        w_active;
    logic [9:0]  w_x;
    logic [8:0]  w_y;
    logic [6:0]  w_col;
    logic [4:0]  w_row;
    logic [2:0]  w_pix;
    logic [3:0]  w_grow;
    logic [11:0] w_addr;
    logic        w_cur;

    assign w_active = (hc >= 10'(HBP)) && (hc < 10'(HBP + HACT)) &&
                      (vc >= 10'(VBP)) && (vc < 10'(VBP + VACT));
    assign w_x    = hc - 10'(HBP);
    assign w_y    = 9'(vc - 10'(VBP));
    assign w_col  = w_x[9:3];
    assign w_row  = w_y[8:4];
    assign w_pix  = w_x[2:0];
    assign w_grow = w_y[3:0];

    // row*80 + col as two shifts and an add
    assign w_addr = {1'b0, w_row, 6'b0} + {3'b0, w_row, 4'b0} + {5'b0, w_col};

    // The range guards only matter for out-of-range cursor settings, which must never light a cell.
    assign w_cur = cursor_en && w_active && (w_col == cursor_col) && (w_row == cursor_row) &&
                   (w_grow >= 4'd14) && (cursor_col < 7'(COLS)) && (cursor_row < 5'(ROWS));

    // S1: address and sideband, aligned with the RAM access cycle
    logic       r1_active, r1_cur, r1_hs, r1_vs;
    logic [2:0] r1_pix;
    logic [3:0] r1_grow;
    // S2: sideband delayed to line up with text_data
    logic       r2_active, r2_cur, r2_hs, r2_vs;
    logic [2:0] r2_pix;
    logic [3:0] r2_grow;
    // S3: attributes captured from text_data, aligned with font_data
    logic       r3_active, r3_cur, r3_hs, r3_vs, r3_blink;
    logic [2:0] r3_pix;
    logic [7:0] r3_fg;
    // Blink timebase
    logic       r_vsync_prev;
    logic [5:0] r_frame_cnt;

    assign font_addr = {text_data[6:0], r2_grow};

    always_ff @(posedge dclk) begin
        if (clr) begin
            text_addr    <= '0;
            r1_active    <= 1'b0;
            r1_cur       <= 1'b0;
            r1_hs        <= 1'b1;
            r1_vs        <= 1'b1;
            r1_pix       <= '0;
            r1_grow      <= '0;
            r2_active    <= 1'b0;
            r2_cur       <= 1'b0;
            r2_hs        <= 1'b1;
            r2_vs        <= 1'b1;
            r2_pix       <= '0;
            r2_grow      <= '0;
            r3_active    <= 1'b0;
            r3_cur       <= 1'b0;
            r3_hs        <= 1'b1;
            r3_vs        <= 1'b1;
            r3_blink     <= 1'b0;
            r3_pix       <= '0;
            r3_fg        <= '0;
            r_vsync_prev <= 1'b1;
            r_frame_cnt  <= '0;
        end else begin
            text_addr    <= w_active ? w_addr : 12'd0;
            r1_active    <= w_active;
            r1_cur       <= w_cur;
            r1_hs        <= hsync_in;
            r1_vs        <= vsync_in;
            r1_pix       <= w_pix;
            r1_grow      <= w_grow;

            r2_active    <= r1_active;
            r2_cur       <= r1_cur;
            r2_hs        <= r1_hs;
            r2_vs        <= r1_vs;
            r2_pix       <= r1_pix;
            r2_grow      <= r1_grow;

            r3_active    <= r2_active;
            r3_cur       <= r2_cur;
            r3_hs        <= r2_hs;
            r3_vs        <= r2_vs;
            r3_pix       <= r2_pix;
            r3_blink     <= text_data[7];
            r3_fg        <= text_data[15:8];

            // Frame counter advances on each vsync falling edge
            r_vsync_prev <= vsync_in;
            if (r_vsync_prev && !vsync_in)
                r_frame_cnt <= r_frame_cnt + 6'd1;
        end
    end

    // S4: pixel decision. Blinking text is hidden in phase 0; the cursor shows in phase 1 and wins over blink.
    logic w_phase, w_glyph, w_on;
    assign w_phase = r_frame_cnt[5];
    assign w_glyph = font_data[3'd7 - r3_pix];
    assign w_on    = (w_glyph && !(r3_blink && !w_phase)) || (r3_cur && w_phase);

    always_ff @(posedge dclk) begin
        if (clr) begin
            rgb       <= '0;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
        end else begin
            rgb       <= (r3_active && w_on) ? r3_fg : 8'h00;
            hsync_out <= r3_hs;
            vsync_out <= r3_vs;
        end
    end

endmodule

// File: tb/tb_vga_text_renderer.sv
// Directed bench for vga_text_renderer: table-driven streaming vectors plus hand sequences for reset, blink and mid-line reset.
// Inputs are driven 1 time unit after each rising edge and outputs sampled at the same point.
// The RAM/ROM models are synchronous 1-cycle reads whose contents are set by bench variables.
module tb_vga_text_renderer;

    logic        dclk = 1'b0;
    logic        clr = 1'b1;
    logic [9:0]  hc = '0;
    logic [9:0]  vc = '0;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic [11:0] text_addr;
    logic [15:0] text_data = '0;
    logic [10:0] font_addr;
    logic [7:0]  font_data = '0;
    logic        cursor_en = 1'b0;
    logic [6:0]  cursor_col = '0;
    logic [4:0]  cursor_row = '0;
    logic [7:0]  rgb;
    logic        hsync_out;
    logic        vsync_out;

    // Memory contents used by the models
    logic [7:0]  t_fg = 8'hE0;
    logic        t_blink = 1'b0;
    logic [7:0]  f_row = 8'h81;

    int n_checks = 0;
    int n_errors = 0;

    vga_text_renderer dut (
        .dclk(dclk), .clr(clr), .hc(hc), .vc(vc),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .text_addr(text_addr), .text_data(text_data),
        .font_addr(font_addr), .font_data(font_data),
        .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
        .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out)
    );

    always #20 dclk = ~dclk;

    // Every cell holds char 0x41 while the address is legal; font only has a glyph for 0x41
    always @(posedge dclk) begin
        text_data <= {t_fg, t_blink, (text_addr < 12'd2400) ? 7'h41 : 7'h00};
        font_data <= (font_addr[10:4] == 7'h41) ? f_row : 8'h00;
    end

    typedef struct {
        logic [9:0]  hc;
        logic [9:0]  vc;
        logic        hs;
        logic        vs;
        logic [7:0]  exp_rgb;
        logic        exp_hs;
        logic        exp_vs;
        logic [11:0] exp_addr;
        logic        chk_addr;
    } vec_t;

    vec_t tbl[$];

    task automatic tick();
        @(posedge dclk);
        #1;
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d] got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic [9:0] h, input logic [9:0] v, input logic hs, input logic vs);
        hc = h;
        vc = v;
        hsync_in = hs;
        vsync_in = vs;
    endtask

    task automatic do_reset();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic pulse_frames(input int n);
        for (int k = 0; k < n; k++) begin
            vsync_in = 1'b0;
            tick();
            vsync_in = 1'b1;
            tick();
        end
    endtask

    // Streams the table back to back: text_addr checked one edge after each input, pixel/syncs four edges after.
    task automatic run_table(input string nm);
        for (int i = 0; i < tbl.size() + 3; i++) begin
            if (i < tbl.size()) drive(tbl[i].hc, tbl[i].vc, tbl[i].hs, tbl[i].vs);
            else                drive(10'd0, 10'd0, 1'b1, 1'b1);
            tick();
            if (i < tbl.size() && tbl[i].chk_addr)
                chk({nm, "_addr"}, i, 32'(text_addr), 32'(tbl[i].exp_addr));
            if (i >= 3) begin
                vec_t v;
                v = tbl[i-3];
                chk({nm, "_rgb"}, i-3, 32'(rgb), 32'(v.exp_rgb));
                chk({nm, "_hs"},  i-3, 32'(hsync_out), 32'(v.exp_hs));
                chk({nm, "_vs"},  i-3, 32'(vsync_out), 32'(v.exp_vs));
            end
        end
    endtask

    // Holds one position, lets the pipeline settle, then checks the pixel
    task automatic hold_check(input string nm, input int idx, input logic [9:0] h, input logic [9:0] v, input logic [7:0] exp);
        drive(h, v, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) tick();
        chk(nm, idx, 32'(rgb), 32'(exp));
    endtask

    initial begin
        // Reset held with random inputs
        clr = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(10'($urandom_range(0, 799)), 10'($urandom_range(0, 520)), 1'($urandom), 1'($urandom));
            t_fg = 8'($urandom);
            f_row = 8'($urandom);
            tick();
            chk("rst_rgb",  k, 32'(rgb), 32'h00);
            chk("rst_hs",   k, 32'(hsync_out), 32'h1);
            chk("rst_vs",   k, 32'(vsync_out), 32'h1);
            chk("rst_addr", k, 32'(text_addr), 32'h0);
        end
        clr = 1'b0;
        t_fg = 8'hE0;
        f_row = 8'h81;
        t_blink = 1'b0;

        // Character 0x41, fg E0, font row 0x81: lit at pix_x 0 and 7 only
        tbl.delete();
        tbl.push_back(vec_t'{10'd144, 10'd31,  1'b1, 1'b1, 8'hE0, 1'b1, 1'b1, 12'd0,    1'b1});
        tbl.push_back(vec_t'{10'd145, 10'd31,  1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 12'd0,    1'b1});
        tbl.push_back(vec_t'{10'd151, 10'd31,  1'b1, 1'b1, 8'hE0, 1'b1, 1'b1, 12'd0,    1'b1});
        tbl.push_back(vec_t'{10'd784, 10'd31,  1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 12'd0,    1'b1});
        tbl.push_back(vec_t'{10'd783, 10'd31,  1'b1, 1'b1, 8'hE0, 1'b1, 1'b1, 12'd79,   1'b1});
        tbl.push_back(vec_t'{10'd776, 10'd31,  1'b1, 1'b1, 8'hE0, 1'b1, 1'b1, 12'd79,   1'b1});
        tbl.push_back(vec_t'{10'd144, 10'd47,  1'b1, 1'b1, 8'hE0, 1'b1, 1'b1, 12'd80,   1'b1});
        tbl.push_back(vec_t'{10'd783, 10'd510, 1'b1, 1'b1, 8'hE0, 1'b1, 1'b1, 12'd2399, 1'b1});
        tbl.push_back(vec_t'{10'd783, 10'd511, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 12'd0,    1'b1});
        tbl.push_back(vec_t'{10'd143, 10'd31,  1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 12'd0,    1'b1});
        tbl.push_back(vec_t'{10'd148, 10'd100, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 12'd320,  1'b1});
        tbl.push_back(vec_t'{10'd0,   10'd0,   1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 12'd0,    1'b1});
        tbl.push_back(vec_t'{10'd1,   10'd0,   1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 12'd0,    1'b1});
        tbl.push_back(vec_t'{10'd152, 10'd31,  1'b1, 1'b1, 8'hE0, 1'b1, 1'b1, 12'd1,    1'b1});
        tbl.push_back(vec_t'{10'd400, 10'd200, 1'b1, 1'b1, 8'hE0, 1'b1, 1'b1, 12'd832,  1'b1});
        tbl.push_back(vec_t'{10'd799, 10'd520, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 12'd0,    1'b1});
        run_table("pix");

        // Blinking char, solid font: hidden while frame_cnt[5]=0, shown while 1
        do_reset();
        t_blink = 1'b1;
        f_row = 8'hFF;
        drive(10'd144, 10'd31, 1'b1, 1'b1);
        hold_check("blink", 0, 10'd144, 10'd31, 8'h00);
        pulse_frames(31);
        hold_check("blink", 31, 10'd144, 10'd31, 8'h00);
        pulse_frames(1);
        hold_check("blink", 32, 10'd144, 10'd31, 8'hE0);
        pulse_frames(31);
        hold_check("blink", 63, 10'd144, 10'd31, 8'hE0);
        pulse_frames(1);
        hold_check("blink", 64, 10'd144, 10'd31, 8'h00);

        // Cursor at col 5 row 2 on a blank font, blink phase 1
        do_reset();
        t_blink = 1'b0;
        f_row = 8'h00;
        t_fg = 8'h1C;
        cursor_en = 1'b1;
        cursor_col = 7'd5;
        cursor_row = 5'd2;
        pulse_frames(32);
        tbl.delete();
        tbl.push_back(vec_t'{10'd184, 10'd77, 1'b1, 1'b1, 8'h1C, 1'b1, 1'b1, 12'd165, 1'b1});
        tbl.push_back(vec_t'{10'd191, 10'd78, 1'b1, 1'b1, 8'h1C, 1'b1, 1'b1, 12'd165, 1'b1});
        tbl.push_back(vec_t'{10'd192, 10'd77, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 12'd166, 1'b1});
        tbl.push_back(vec_t'{10'd183, 10'd77, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 12'd164, 1'b1});
        tbl.push_back(vec_t'{10'd184, 10'd76, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 12'd165, 1'b1});
        tbl.push_back(vec_t'{10'd184, 10'd79, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 12'd245, 1'b1});
        tbl.push_back(vec_t'{10'd188, 10'd78, 1'b1, 1'b1, 8'h1C, 1'b1, 1'b1, 12'd165, 1'b1});
        tbl.push_back(vec_t'{10'd190, 10'd62, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 12'd85,  1'b1});
        run_table("cur");
        pulse_frames(32);
        hold_check("cur_phase0", 0, 10'd184, 10'd77, 8'h00);
        pulse_frames(32);
        hold_check("cur_phase1", 0, 10'd186, 10'd78, 8'h1C);
        cursor_en = 1'b0;
        hold_check("cur_off", 0, 10'd186, 10'd78, 8'h00);
        cursor_en = 1'b1;
        cursor_col = 7'd85;
        hold_check("cur_range", 0, 10'd186, 10'd78, 8'h00);
        cursor_en = 1'b0;

        // Mid-line reset: pipeline full of lit pixels with hsync low, then clr at hc=400
        do_reset();
        t_fg = 8'hE0;
        f_row = 8'hFF;
        drive(10'd396, 10'd31, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) tick();
        chk("pre_rst_rgb", 0, 32'(rgb), 32'hE0);
        chk("pre_rst_hs",  0, 32'(hsync_out), 32'h0);
        drive(10'd400, 10'd31, 1'b0, 1'b1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("mid_rst_rgb", 0, 32'(rgb), 32'h00);
        chk("mid_rst_hs",  0, 32'(hsync_out), 32'h1);
        for (int k = 1; k <= 3; k++) begin
            drive(10'(400 + k), 10'd31, (k == 1) ? 1'b0 : 1'b1, 1'b1);
            tick();
            chk("mid_rst_rgb", k, 32'(rgb), 32'h00);
            chk("mid_rst_hs",  k, 32'(hsync_out), 32'h1);
        end
        drive(10'd404, 10'd31, 1'b1, 1'b1);
        tick();
        chk("resume_rgb", 0, 32'(rgb), 32'hE0);
        chk("resume_hs",  0, 32'(hsync_out), 32'h0);
        drive(10'd405, 10'd31, 1'b1, 1'b1);
        tick();
        chk("resume_rgb", 1, 32'(rgb), 32'hE0);
        chk("resume_hs",  1, 32'(hsync_out), 32'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
